// File: rtl/instruction_fetch_stage_pkg.sv
// Package for the instruction fetch stage.
// Contents:
//   fetch_state_t - fetch FSM states (BOOT, RUN, HOLD)
//   PC_STEP       - sequential PC increment (one 32-bit word)
//   NOP_WORD      - instruction word written into IF/ID on a bubble
//   if_id_t       - IF/ID pipeline register bundle
//   word_align()  - clears address bits [1:0]
package instruction_fetch_stage_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   localparam logic [31:0] PC_STEP  = 32'd4;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] instruction;
      logic [31:0] pcplus4;
   } if_id_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Interface between the fetch stage, the instruction memory and the
// hazard/branch logic of later stages.
// Signals:
//   Instruction        memory -> fetch  word read combinationally at PCResult
//   Stall              hazard -> fetch  hold PC and IF/ID
//   Redirect           branch -> fetch  load RedirectPC, squash current fetch
//   RedirectPC         branch -> fetch  redirect target (bits [1:0] ignored)
//   PCResult           fetch -> memory  current PC
//   IF_ID_Instruction  fetch -> decode  registered instruction
//   IF_ID_PCPlus4      fetch -> decode  registered PC+4
//   IF_ID_Valid        fetch -> decode  1 = real instruction, 0 = bubble
//   AddrFault          fetch -> decode  fetch address beyond memory size
// Optional (macro FETCH_PERF_CNT_EN): FetchCount, BubbleCount.
// Modports: master = fetch stage, slave = surrounding pipeline/memory.
interface instruction_fetch_stage_if;

   logic [31:0] Instruction;
   logic        Stall;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic [31:0] PCResult;
   logic [31:0] IF_ID_Instruction;
   logic [31:0] IF_ID_PCPlus4;
   logic        IF_ID_Valid;
   logic        AddrFault;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] FetchCount;
   logic [31:0] BubbleCount;
`endif

   modport master (
      input  Instruction,
      input  Stall,
      input  Redirect,
      input  RedirectPC,
      output PCResult,
      output IF_ID_Instruction,
      output IF_ID_PCPlus4,
      output IF_ID_Valid,
`ifdef FETCH_PERF_CNT_EN
      output FetchCount,
      output BubbleCount,
`endif
      output AddrFault
   );

   modport slave (
      output Instruction,
      output Stall,
      output Redirect,
      output RedirectPC,
      input  PCResult,
      input  IF_ID_Instruction,
      input  IF_ID_PCPlus4,
      input  IF_ID_Valid,
`ifdef FETCH_PERF_CNT_EN
      input  FetchCount,
      input  BubbleCount,
`endif
      input  AddrFault
   );

endinterface

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (clears to a bubble)
//   hold  keep current contents
//   clear load a bubble (takes priority over hold)
//   d     bundle captured when neither hold nor clear
//   q     registered bundle
module if_id_register
   import instruction_fetch_stage_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   hold,
   input  logic   clear,
   input  if_id_t d,
   output if_id_t q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clear) begin
         q.valid       <= 1'b0;
         q.instruction <= NOP_WORD;
         q.pcplus4     <= '0;
      end else if (!hold) begin
         q <= d;
      end
   end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives it to the instruction memory
// and captures the returned word into the IF/ID register.
// Parameters:
//   RESET_PC  PC after reset (bits [1:0] forced to 0)
//   IMEM_AW   instruction memory word-index width
// Ports:
//   Clk, Reset  clock and asynchronous active-high reset
//   bus         instruction_fetch_stage_if.master (see interface file)
// Optional feature: define FETCH_PERF_CNT_EN to add FetchCount/BubbleCount.
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned IMEM_AW  = 10
)
(
   input  logic                       Clk,
   input  logic                       Reset,
   instruction_fetch_stage_if.master  bus
);

   localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;
   // Address bits above the memory's byte range; any set bit means the
   // fetch aliases back into the array.
   localparam logic [31:0] FAULT_MASK = ~((32'd1 << (IMEM_AW + 2)) - 32'd1);

   fetch_state_t state, next_state;
   logic [31:0]  pc, pc_next, pc_plus4;
   logic         hold, squash;
   logic         addr_fault;
   if_id_t       if_id_d, if_id_q;

   assign pc_plus4 = pc + PC_STEP;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= BOOT;
      end else begin
         state <= next_state;
      end
   end

   // Redirect wins over Stall; Stall is ignored in BOOT so the boot word
   // is always captured (unless a redirect drops it).
   always_comb begin
      next_state = RUN;
      hold       = 1'b0;
      squash     = 1'b0;
      pc_next    = pc_plus4;
      if (bus.Redirect) begin
         squash  = 1'b1;
         pc_next = word_align(bus.RedirectPC);
      end else if (bus.Stall && (state != BOOT)) begin
         next_state = HOLD;
         hold       = 1'b1;
         pc_next    = pc;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pc         <= RESET_PC_ALIGNED;
         addr_fault <= 1'b0;
      end else begin
         pc <= pc_next;
         if (!hold) begin
            addr_fault <= |(pc & FAULT_MASK);
         end
      end
   end

   always_comb begin
      if_id_d.valid       = 1'b1;
      if_id_d.instruction = bus.Instruction;
      if_id_d.pcplus4     = pc_plus4;
   end

   if_id_register u_if_id (
      .clk   (Clk),
      .rst   (Reset),
      .hold  (hold),
      .clear (squash),
      .d     (if_id_d),
      .q     (if_id_q)
   );

   assign bus.PCResult          = pc;
   assign bus.IF_ID_Instruction = if_id_q.instruction;
   assign bus.IF_ID_PCPlus4     = if_id_q.pcplus4;
   assign bus.IF_ID_Valid       = if_id_q.valid;
   assign bus.AddrFault         = addr_fault;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count, bubble_count;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fetch_count  <= '0;
         bubble_count <= '0;
      end else begin
         if (!hold && !squash) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if (hold || squash) begin
            bubble_count <= bubble_count + 32'd1;
         end
      end
   end

   assign bus.FetchCount  = fetch_count;
   assign bus.BubbleCount = bubble_count;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

   logic Clk = 1'b0;
   logic Reset;
   logic [31:0] mem [1024];

   int checks = 0;
   int failures = 0;

   instruction_fetch_stage_if bus ();

   instruction_fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .IMEM_AW  (10)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   assign bus.Instruction = mem[bus.PCResult[11:2]];

   // Reference model state (what the pipeline should hold after each edge)
   logic [31:0] m_pc, m_ins, m_p4;
   logic        m_v, m_af, m_booted;
   logic [31:0] m_fetch, m_bubble;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic fault_of(input logic [31:0] a);
      return a >= 32'd4096;
   endfunction

   function automatic logic [31:0] fetch_word(input logic [31:0] a);
      return mem[(a / 4) % 1024];
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_ins = 32'h0; m_p4 = 32'h0; m_v = 1'b0; m_af = 1'b0;
      m_booted = 1'b0; m_fetch = 32'h0; m_bubble = 32'h0;
   endtask

   task automatic check_all(input string where);
      chk({where, ".pc"},    bus.PCResult, m_pc);
      chk({where, ".ins"},   bus.IF_ID_Instruction, m_ins);
      chk({where, ".pc4"},   bus.IF_ID_PCPlus4, m_p4);
      chk({where, ".valid"}, {31'b0, bus.IF_ID_Valid}, {31'b0, m_v});
      chk({where, ".fault"}, {31'b0, bus.AddrFault}, {31'b0, m_af});
`ifdef FETCH_PERF_CNT_EN
      chk({where, ".fcnt"},  bus.FetchCount, m_fetch);
      chk({where, ".bcnt"},  bus.BubbleCount, m_bubble);
`endif
   endtask

   // One clock edge: drive inputs, advance the model by the spec rules,
   // then compare one time unit after the edge.
   task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input string where);
      logic [31:0] n_pc, n_ins, n_p4;
      logic        n_v, n_af;
      n_pc = m_pc; n_ins = m_ins; n_p4 = m_p4; n_v = m_v; n_af = m_af;
      bus.Stall = st; bus.Redirect = rd; bus.RedirectPC = rpc;
      if (rd) begin
         n_af = fault_of(m_pc);
         n_pc = rpc - (rpc % 4);
         n_ins = 32'h0; n_p4 = 32'h0; n_v = 1'b0;
         m_bubble++;
      end else if (st && m_booted) begin
         m_bubble++;
      end else begin
         n_af = fault_of(m_pc);
         n_ins = fetch_word(m_pc);
         n_p4 = m_pc + 32'd4;
         n_v = 1'b1;
         n_pc = m_pc + 32'd4;
         m_fetch++;
      end
      @(posedge Clk);
      #1;
      m_pc = n_pc; m_ins = n_ins; m_p4 = n_p4; m_v = n_v; m_af = n_af;
      m_booted = 1'b1;
      check_all(where);
   endtask

   initial begin
      Reset = 1'b1;
      bus.Stall = 1'b0; bus.Redirect = 1'b0; bus.RedirectPC = 32'h0;
      for (int i = 0; i < 1024; i++) mem[i] = i * 3;
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      check_all("reset");
      Reset = 1'b0;

      // Sequential fetch: 0,3 captured, PC reaches 8
      step(0, 0, 0, "seq0");
      chk("seq0.valid_rise", {31'b0, bus.IF_ID_Valid}, 32'd1);
      step(0, 0, 0, "seq1");
      chk("seq1.ins_is_3", bus.IF_ID_Instruction, 32'd3);
      chk("seq1.pc_is_8", bus.PCResult, 32'd8);

      // Stall three cycles at PC=8
      for (int i = 0; i < 3; i++) step(1, 0, 0, "stall");
      chk("stall.pc_hold", bus.PCResult, 32'd8);
      chk("stall.ins_hold", bus.IF_ID_Instruction, 32'd3);
      step(0, 0, 0, "unstall");
      chk("unstall.ins_is_6", bus.IF_ID_Instruction, 32'd6);

      // Redirect at PC=12 to unaligned 0x43
      step(0, 1, 32'h43, "redir");
      chk("redir.pc_40", bus.PCResult, 32'h40);
      chk("redir.bubble", {31'b0, bus.IF_ID_Valid}, 32'd0);
      step(0, 0, 0, "redir_tgt");
      chk("redir_tgt.ins_48", bus.IF_ID_Instruction, 32'd48);

      // Stall together with Redirect: redirect wins
      step(1, 1, 32'h20, "st_rd");
      chk("st_rd.pc_20", bus.PCResult, 32'h20);
      step(1, 0, 0, "st_after");
      step(0, 0, 0, "run_after");

      // Fetch beyond memory: aliases to word 0 and flags AddrFault
      step(0, 1, 32'h0000_1000, "far");
      step(0, 0, 0, "far_fetch");
      chk("far_fetch.fault", {31'b0, bus.AddrFault}, 32'd1);
      chk("far_fetch.ins_mem0", bus.IF_ID_Instruction, 32'd0);

      // PC wraparound at the top of the address space
      step(0, 1, 32'hFFFF_FFFF, "top");
      step(0, 0, 0, "wrap");
      chk("wrap.pc4_zero", bus.IF_ID_PCPlus4, 32'h0);
      chk("wrap.pc_zero", bus.PCResult, 32'h0);
      step(0, 0, 0, "wrap1");

      // Asynchronous reset mid-stream, then Stall ignored in BOOT
      #2;
      Reset = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      Reset = 1'b0;
      step(1, 0, 0, "boot_stall");
      step(1, 0, 0, "boot_stall_hold");

      // Redirect during BOOT drops the boot word
      #2; Reset = 1'b1; #1; model_reset(); Reset = 1'b0;
      step(0, 1, 32'h100, "boot_redir");
      step(0, 0, 0, "boot_redir_tgt");

      // Randomized traffic with random memory contents
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      for (int i = 0; i < 400; i++) begin
         logic st, rd;
         logic [31:0] rpc;
         st = ($urandom_range(0, 3) == 0);
         rd = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0:       rpc = $urandom;
            1:       rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            default: rpc = $urandom_range(0, 4095);
         endcase
         step(st, rd, rpc, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Pipeline fetch stage that drives the word address into the instruction memory and captures the returned word into the IF/ID pipeline register. It owns the program counter, PC+4 sequencing, branch/jump redirect, stall hold and flush-to-bubble behaviour. It sits between the hazard/branch logic of later stages and the read-only, combinationally-read instruction memory (1024 words, indexed by address bits [11:2]).

## Interface
- RESET_PC, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- IMEM_AW, default 10: instruction memory word-index width; memory sees PCResult[IMEM_AW+1:2].
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Instruction  input  32  word returned combinationally by instruction memory for PCResult.
- Stall  input  1  hazard unit request: hold PC and IF/ID contents.
- Redirect  input  1  taken branch/jump: load RedirectPC, squash the word being fetched.
- RedirectPC  input  32  target address; bits [1:0] ignored, forced to 0.
- PCResult  output  32  current PC, driven to instruction memory.
- IF_ID_Instruction  output  32  registered instruction.
- IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
- IF_ID_Valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
- AddrFault  output  1  registered flag: PCResult[31:IMEM_AW+2] non-zero (fetch wrapped into memory).

## Operation
- States: BOOT, RUN, HOLD.
- BOOT: entered on reset. PC = RESET_PC, IF/ID cleared. First clock edge after Reset deasserts: capture memory[RESET_PC], PC <= RESET_PC+4, go RUN. Stall in BOOT is ignored.
- RUN, no Stall, no Redirect: PC <= PC+4; IF/ID <= {Instruction, PC+4, Valid=1}.
- Stall=1, Redirect=0: go/stay HOLD; PC and all IF/ID outputs unchanged.
- HOLD with Stall=0: behave as RUN on that edge, return to RUN.
- Redirect=1 (any state except BOOT, regardless of Stall): PC <= {RedirectPC[31:2],2'b00}; IF_ID_Valid <= 0, IF_ID_Instruction <= 32'h0, IF_ID_PCPlus4 <= 0; go RUN. Redirect beats Stall.
- Redirect during BOOT: treated as RUN+redirect (boot word dropped).
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 = 0, no flag.
- AddrFault updates every non-held edge from the PC being fetched; held during HOLD; sticky not required.

## Timing
- Reset values: PCResult = RESET_PC, IF_ID_Instruction = 0, IF_ID_PCPlus4 = 0, IF_ID_Valid = 0, AddrFault = 0, state = BOOT.
- Reset asserted mid-operation clears immediately (asynchronous), no clock needed.
- Fetch latency: word at PCResult appears on IF_ID_Instruction one edge later.
- Redirect penalty: one bubble; target's word valid two edges after Redirect sampled.
- Stall, Redirect, RedirectPC sampled on rising edge only; no combinational path from them to PCResult.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs FetchCount[31:0] (increments on each edge capturing Valid=1) and BubbleCount[31:0] (increments on each HOLD edge or redirect squash); both reset to 0, wrap modulo 2^32.
- Undefined: ports and counters absent; core behaviour identical.

## Structure
- Shared package: fetch state enum (BOOT/RUN/HOLD), PC_STEP = 4, NOP_WORD = 32'h0, IF/ID bundle typedef.
- One natural sub-module: if_id_register (Valid/Instruction/PCPlus4 latch with hold and clear); PC and FSM stay in top.

## Test plan
- Reset with RESET_PC=0, memory[i]=i*3, release -> IF/ID gets 0,3,6,9 on successive edges with PCPlus4 4,8,12,16; Valid rises one edge after release.
- Stall high 3 cycles at PC=8 -> PCResult stays 8, IF_ID_Instruction holds 3; on release next capture is 6.
- Redirect with RedirectPC=32'h43 at PC=12 -> next edge Valid=0, PCResult=32'h40; following edge IF_ID_Instruction = 48 (16*3).
- Stall and Redirect together (RedirectPC=32'h20) -> redirect wins: PCResult=32'h20, Valid=0.
- Redirect to 32'h0000_1000 -> AddrFault=1 with instruction = memory[0]; Reset mid-stream -> all outputs return to reset values without clock edge.
- With FETCH_PERF_CNT_EN: 10 free-run edges, 2 stall, 1 redirect -> FetchCount and BubbleCount match captured Valid/bubble totals exactly.
